spi_slave_fifo: RTL and testbench

Parametrised SPI target that samples an external SPI bus in the system `clk` domain. It supports all four SPI modes and multi-word frames. Received words queue in an RX FIFO with a valid/ready handshake. A single-word TX holding register drives `sdo` full-duplex. It sits between the MCU SPI pins and the game logic, and replaces the single-word CE-latched receiver with a buffered, flow-controlled, mode-configurable interface that reports errors.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_fifo_if.sv | 31 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/synchronizer.sv | 25 ++
 rtl/spi_slave_fifo.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/spi_pkg.sv
// Shared types and mode helpers for the SPI target with RX FIFO.
package spi_pkg;

    // Frame state: waiting for chip enable, or inside a frame.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // True when data is sampled on the leading sck edge (CPHA = 0).
    function automatic bit lead_sample(input int cpha);
        return (cpha == 0);
    endfunction

endpackage

// File: rtl/spi_slave_fifo_if.sv
// Parallel-side bus of the SPI target: RX FIFO, TX holding register, status.
interface spi_slave_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [LW-1:0]    rx_level;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             frame_done;
    logic             overrun;
    logic             underrun;
    logic             clear;

    // The SPI target drives RX/status and consumes TX/handshake inputs.
    modport slave (
        output rx_data, rx_valid, rx_level, tx_ready, frame_done, overrun, underrun,
        input  rx_ready, tx_data, tx_valid, clear
    );

    // The game logic side sees the mirror image.
    modport master (
        input  rx_data, rx_valid, rx_level, tx_ready, frame_done, overrun, underrun,
        output rx_ready, tx_data, tx_valid, clear
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Storage and pointer update; reset clears contents so the head reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for one asynchronous pin, with a selectable reset level.
module synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Resample the pin twice in the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/spi_slave_fifo.sv
// SPI target sampled in the clk domain: all four modes, multi-word frames,
// RX FIFO with valid/ready, single-word TX holding register, sticky errors.
module spi_slave_fifo
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             sdi,
    input  logic             ce,
    output logic             sdo,
    spi_slave_fifo_if.slave  bus
);
    localparam bit             LEAD_SAMPLE = lead_sample(CPHA);
    localparam int             CW          = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT    = CW'(WIDTH - 1);
    localparam logic           SCK_IDLE    = (CPOL != 0) ? 1'b1 : 1'b0;

    logic sck_s, sdi_s, ce_s;
    logic sck_q, ce_q;
    spi_state_t       state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] rx_shift_q;
    logic [WIDTH-1:0] tx_shift_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             frame_done_q;
    logic             overrun_q;
    logic             underrun_q;

    logic sck_rise_s, sck_fall_s, lead_s, trail_s, sample_s, shift_s;
    logic ce_rise_s, ce_fall_s, in_frame_s;
    logic word_done_s, tx_load_s, tx_shift_en_s;
    logic fifo_full_s, fifo_empty_s, pop_s, drop_s;
    logic [WIDTH-1:0] rx_word_s;
    logic [WIDTH-1:0] fifo_head_s;
    logic [$clog2(DEPTH):0] fifo_level_s;

    // ce resets high so a chip enable already asserted at reset is not a rise.
    synchronizer #(.RESET_VAL(SCK_IDLE)) u_sync_sck (.clk(clk), .reset(reset), .d_i(sck), .q_o(sck_s));
    synchronizer #(.RESET_VAL(1'b0))     u_sync_sdi (.clk(clk), .reset(reset), .d_i(sdi), .q_o(sdi_s));
    synchronizer #(.RESET_VAL(1'b1))     u_sync_ce  (.clk(clk), .reset(reset), .d_i(ce),  .q_o(ce_s));

    // Third register on synced sck and ce for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q <= SCK_IDLE;
            ce_q  <= 1'b1;
        end else begin
            sck_q <= sck_s;
            ce_q  <= ce_s;
        end
    end

    assign sck_rise_s = sck_s & ~sck_q;
    assign sck_fall_s = ~sck_s & sck_q;
    assign lead_s     = (CPOL != 0) ? sck_fall_s : sck_rise_s;
    assign trail_s    = (CPOL != 0) ? sck_rise_s : sck_fall_s;
    assign sample_s   = LEAD_SAMPLE ? lead_s : trail_s;
    assign shift_s    = LEAD_SAMPLE ? trail_s : lead_s;
    assign ce_rise_s  = ce_s & ~ce_q;
    assign ce_fall_s  = ~ce_s & ce_q;
    assign in_frame_s = (state_q == ACTIVE) && !ce_fall_s;
    assign rx_word_s  = {rx_shift_q[WIDTH-2:0], sdi_s};

    // Decode per-cycle frame events: word completion, TX load and TX shift.
    always_comb begin
        word_done_s   = in_frame_s && sample_s && (bit_cnt_q == LAST_BIT);
        tx_load_s     = 1'b0;
        tx_shift_en_s = 1'b0;
        if (state_q == IDLE) begin
            tx_load_s = LEAD_SAMPLE && ce_rise_s;
        end else if (in_frame_s) begin
            // CPHA=0 preloads the next word at completion; CPHA=1 loads on the
            // first shift edge. The shift edge right after completion is skipped.
            tx_load_s     = LEAD_SAMPLE ? word_done_s : (shift_s && (bit_cnt_q == '0));
            tx_shift_en_s = shift_s && (bit_cnt_q != '0);
        end else begin
            tx_load_s = 1'b0;
        end
    end

    // Frame FSM with RX shift register, bit counter and frame_done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ce_rise_s) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= '0;
                    end
                end
                ACTIVE: begin
                    if (ce_fall_s) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                        bit_cnt_q    <= '0;
                    end else if (sample_s) begin
                        rx_shift_q <= rx_word_s;
                        bit_cnt_q  <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // TX holding register and output shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
        end else begin
            if (tx_load_s) begin
                tx_shift_q  <= hold_full_q ? hold_q : '0;
                hold_full_q <= 1'b0;
            end else if (tx_shift_en_s) begin
                tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
            end
            // A write can only land while empty, so a same-cycle load used the old content.
            if (bus.tx_valid && !hold_full_q) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign pop_s  = bus.rx_ready && !fifo_empty_s;
    assign drop_s = word_done_s && fifo_full_s && !pop_s;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (drop_s) begin
                overrun_q <= 1'b1;
            end else if (bus.clear) begin
                overrun_q <= 1'b0;
            end
            if (tx_load_s && !hold_full_q) begin
                underrun_q <= 1'b1;
            end else if (bus.clear) begin
                underrun_q <= 1'b0;
            end
        end
    end

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (word_done_s),
        .pop_i   (pop_s),
        .wdata_i (rx_word_s),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    assign sdo            = tx_shift_q[WIDTH-1];
    assign bus.rx_data    = fifo_head_s;
    assign bus.rx_valid   = !fifo_empty_s;
    assign bus.rx_level   = fifo_level_s;
    assign bus.tx_ready   = !hold_full_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench: one DUT per SPI mode (index = mode), a bit-banged master,
// hand-computed expected words and flags.
`timescale 1ns/1ps
module tb_spi_slave_fifo;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sdi = 1'b0;
    logic [3:0] sck_m = 4'b1100;
    logic [3:0] ce_m  = 4'b0000;
    logic [3:0] rdy_m = 4'b0000;
    logic [3:0] txv_m = 4'b0000;
    logic [3:0] clr_m = 4'b0000;
    logic [7:0] txd_m [4];
    logic [3:0] sdo_m, rxv_m, txr_m, fd_m, ovr_m, und_m;
    logic [7:0] rxd_m [4];
    logic [2:0] lvl_m [4];
    int fd_cnt [4] = '{0, 0, 0, 0};
    int tests_run = 0;
    int tests_failed = 0;
    logic rxv_at2, rxv_at4;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();
        assign bus.rx_ready = rdy_m[g];
        assign bus.tx_data  = txd_m[g];
        assign bus.tx_valid = txv_m[g];
        assign bus.clear    = clr_m[g];
        assign rxd_m[g] = bus.rx_data;
        assign rxv_m[g] = bus.rx_valid;
        assign lvl_m[g] = bus.rx_level;
        assign txr_m[g] = bus.tx_ready;
        assign fd_m[g]  = bus.frame_done;
        assign ovr_m[g] = bus.overrun;
        assign und_m[g] = bus.underrun;
        spi_slave_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(g / 2), .CPHA(g % 2)) dut (
            .clk(clk), .reset(reset), .sck(sck_m[g]), .sdi(sdi), .ce(ce_m[g]),
            .sdo(sdo_m[g]), .bus(bus.slave)
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fd_m[i]) fd_cnt[i] <= fd_cnt[i] + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_wait(input bit last, input int m);
        wait_clk(2);
        if (last) rxv_at2 = rxv_m[m];
        wait_clk(2);
        if (last) rxv_at4 = rxv_m[m];
        wait_clk(HALF - 4);
    endtask

    task automatic spi_bits(input int m, input int nbits, input logic [63:0] mosi,
                            output logic [63:0] miso);
        logic cpol, cpha;
        cpol = (m >= 2) ? 1'b1 : 1'b0;
        cpha = (m % 2 == 1) ? 1'b1 : 1'b0;
        miso = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                sdi = mosi[i];
                wait_clk(HALF);
                miso[i] = sdo_m[m];
                sck_m[m] = ~cpol;
                edge_wait(i == 0, m);
                sck_m[m] = cpol;
            end else begin
                sck_m[m] = ~cpol;
                sdi = mosi[i];
                wait_clk(HALF);
                miso[i] = sdo_m[m];
                sck_m[m] = cpol;
                edge_wait(i == 0, m);
            end
        end
    endtask

    task automatic spi_frame(input int m, input int nbits, input logic [63:0] mosi,
                             output logic [63:0] miso);
        ce_m[m] = 1'b1;
        wait_clk(8);
        spi_bits(m, nbits, mosi, miso);
        wait_clk(HALF);
        ce_m[m] = 1'b0;
        wait_clk(8);
    endtask

    task automatic tx_write(input int m, input logic [7:0] v);
        txd_m[m] = v;
        txv_m[m] = 1'b1;
        wait_clk(1);
        txv_m[m] = 1'b0;
    endtask

    task automatic pop(input int m);
        rdy_m[m] = 1'b1;
        wait_clk(1);
        rdy_m[m] = 1'b0;
    endtask

    task automatic clear_flags(input int m);
        clr_m[m] = 1'b1;
        wait_clk(1);
        clr_m[m] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(3);
        tests_run++; if (sdo_m[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_sdo got %b exp 0", sdo_m[0]); end
        tests_run++; if (rxv_m !== 4'h0) begin tests_failed++; $display("FAIL reset_rx_valid got %h exp 0", rxv_m); end
        tests_run++; if (rxd_m[0] !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got %h exp 00", rxd_m[0]); end
        tests_run++; if (lvl_m[0] !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", lvl_m[0]); end
        tests_run++; if (txr_m !== 4'hF) begin tests_failed++; $display("FAIL reset_tx_ready got %h exp f", txr_m); end
        tests_run++; if ({fd_m, ovr_m, und_m} !== 12'h000) begin tests_failed++; $display("FAIL reset_flags got %h exp 000", {fd_m, ovr_m, und_m}); end
        reset = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mode0();
        logic [63:0] miso;
        int fd0;
        tx_write(0, 8'h3C);
        tests_run++; if (txr_m[0] !== 1'b0) begin tests_failed++; $display("FAIL m0_tx_ready_full got %b exp 0", txr_m[0]); end
        fd0 = fd_cnt[0];
        spi_frame(0, 8, 64'hA5, miso);
        tests_run++; if (miso[7:0] !== 8'h3C) begin tests_failed++; $display("FAIL m0_sdo got %h exp 3c", miso[7:0]); end
        tests_run++; if (rxd_m[0] !== 8'hA5) begin tests_failed++; $display("FAIL m0_rx_data got %h exp a5", rxd_m[0]); end
        tests_run++; if ({rxv_at2, rxv_at4} !== 2'b01) begin tests_failed++; $display("FAIL m0_rx_latency got %b exp 01", {rxv_at2, rxv_at4}); end
        tests_run++; if (fd_cnt[0] - fd0 !== 1) begin tests_failed++; $display("FAIL m0_frame_done got %0d exp 1", fd_cnt[0] - fd0); end
        tests_run++; if (txr_m[0] !== 1'b1) begin tests_failed++; $display("FAIL m0_tx_ready_empty got %b exp 1", txr_m[0]); end
        pop(0);
        tests_run++; if (rxv_m[0] !== 1'b0) begin tests_failed++; $display("FAIL m0_pop got %b exp 0", rxv_m[0]); end
        clear_flags(0);
    endtask

    task automatic test_modes();
        logic [63:0] miso;
        for (int m = 1; m < 4; m++) begin
            tx_write(m, 8'hC3);
            spi_frame(m, 8, 64'h5A, miso);
            tests_run++; if (miso[7:0] !== 8'hC3) begin tests_failed++; $display("FAIL mode%0d_sdo got %h exp c3", m, miso[7:0]); end
            tests_run++; if (rxd_m[m] !== 8'h5A || rxv_m[m] !== 1'b1) begin tests_failed++; $display("FAIL mode%0d_rx got %h/%b exp 5a/1", m, rxd_m[m], rxv_m[m]); end
            pop(m);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] miso;
        logic [7:0] exp_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        spi_frame(0, 40, 64'h11_22_33_44_55, miso);
        tests_run++; if (lvl_m[0] !== 3'd4) begin tests_failed++; $display("FAIL ovr_level got %0d exp 4", lvl_m[0]); end
        tests_run++; if (ovr_m[0] !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got %b exp 1", ovr_m[0]); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (rxd_m[0] !== exp_w[k]) begin tests_failed++; $display("FAIL ovr_word%0d got %h exp %h", k, rxd_m[0], exp_w[k]); end
            pop(0);
        end
        tests_run++; if (lvl_m[0] !== 3'd0) begin tests_failed++; $display("FAIL ovr_drain got %0d exp 0", lvl_m[0]); end
        clear_flags(0);
        tests_run++; if (ovr_m[0] !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b exp 0", ovr_m[0]); end
    endtask

    task automatic test_partial();
        logic [63:0] miso;
        int fd0;
        fd0 = fd_cnt[0];
        spi_frame(0, 5, 64'h1B, miso);
        tests_run++; if (lvl_m[0] !== 3'd0 || rxv_m[0] !== 1'b0) begin tests_failed++; $display("FAIL partial_no_push got %0d/%b exp 0/0", lvl_m[0], rxv_m[0]); end
        tests_run++; if (fd_cnt[0] - fd0 !== 1) begin tests_failed++; $display("FAIL partial_frame_done got %0d exp 1", fd_cnt[0] - fd0); end
        spi_frame(0, 8, 64'h3E, miso);
        tests_run++; if (rxd_m[0] !== 8'h3E || lvl_m[0] !== 3'd1) begin tests_failed++; $display("FAIL partial_next got %h/%0d exp 3e/1", rxd_m[0], lvl_m[0]); end
        pop(0);
        clear_flags(0);
    endtask

    task automatic test_underrun();
        logic [63:0] miso;
        tests_run++; if (und_m[0] !== 1'b0) begin tests_failed++; $display("FAIL und_cleared got %b exp 0", und_m[0]); end
        tx_write(0, 8'h81);
        spi_frame(0, 16, 64'h1234, miso);
        tests_run++; if (miso[15:0] !== 16'h8100) begin tests_failed++; $display("FAIL und_sdo got %h exp 8100", miso[15:0]); end
        tests_run++; if (und_m[0] !== 1'b1) begin tests_failed++; $display("FAIL und_flag got %b exp 1", und_m[0]); end
        tests_run++; if (lvl_m[0] !== 3'd2 || rxd_m[0] !== 8'h12) begin tests_failed++; $display("FAIL und_rx0 got %0d/%h exp 2/12", lvl_m[0], rxd_m[0]); end
        pop(0);
        tests_run++; if (rxd_m[0] !== 8'h34) begin tests_failed++; $display("FAIL und_rx1 got %h exp 34", rxd_m[0]); end
        pop(0);
        clear_flags(0);
    endtask

    task automatic test_reset_midframe();
        logic [63:0] miso;
        int fd0;
        tx_write(0, 8'h77);
        ce_m[0] = 1'b1;
        wait_clk(8);
        spi_bits(0, 4, 64'hF, miso);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        fd0 = fd_cnt[0];
        tests_run++; if (sdo_m[0] !== 1'b0 || txr_m[0] !== 1'b1) begin tests_failed++; $display("FAIL rstmid_tx got %b/%b exp 0/1", sdo_m[0], txr_m[0]); end
        tests_run++; if (rxv_m[0] !== 1'b0 || rxd_m[0] !== 8'h00 || lvl_m[0] !== 3'd0) begin tests_failed++; $display("FAIL rstmid_rx got %b/%h/%0d exp 0/00/0", rxv_m[0], rxd_m[0], lvl_m[0]); end
        tests_run++; if (ovr_m[0] !== 1'b0 || und_m[0] !== 1'b0) begin tests_failed++; $display("FAIL rstmid_flags got %b/%b exp 0/0", ovr_m[0], und_m[0]); end
        spi_bits(0, 8, 64'hFF, miso);
        wait_clk(HALF);
        tests_run++; if (lvl_m[0] !== 3'd0) begin tests_failed++; $display("FAIL rstmid_no_push got %0d exp 0", lvl_m[0]); end
        ce_m[0] = 1'b0;
        wait_clk(8);
        tests_run++; if (fd_cnt[0] - fd0 !== 0) begin tests_failed++; $display("FAIL rstmid_no_frame_done got %0d exp 0", fd_cnt[0] - fd0); end
        spi_frame(0, 8, 64'h96, miso);
        tests_run++; if (rxd_m[0] !== 8'h96 || lvl_m[0] !== 3'd1) begin tests_failed++; $display("FAIL rstmid_next got %h/%0d exp 96/1", rxd_m[0], lvl_m[0]); end
        pop(0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) txd_m[i] = 8'h00;
        test_reset();
        test_mode0();
        test_modes();
        test_overrun();
        test_partial();
        test_underrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
